// File: rtl/rom_ctrl_pkg.sv
// rom_ctrl_pkg: shared types and default geometry for the ROM frame reader
package rom_ctrl_pkg;
  localparam int PIX_DW = 24;
  localparam int DEF_W = 100;
  localparam int DEF_H = 100;
  localparam int NUM_PIX = DEF_W * DEF_H;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} rd_state_t;
  typedef struct packed {
    logic [PIX_DW-1:0] data;
    logic [15:0] x;
    logic [15:0] y;
    logic sof;
    logic eol;
    logic eof;
  } pix_beat_t;
endpackage

// File: rtl/rom_skid_buffer.sv
// rom_skid_buffer: 2-entry FIFO of pixel beats absorbing the ROM read latency
module rom_skid_buffer
  import rom_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  pix_beat_t beat,
  output logic      full,
  output logic [1:0] count,
  output pix_beat_t head
);
  pix_beat_t mem [2];
  logic wr, rd;
  // storage needs no reset: head is masked to zero while empty
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= beat;
  end
  // pointer and occupancy tracking; push and pop may coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= 1'b0;
      rd <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wr <= ~wr;
      if (pop) rd <= ~rd;
      count <= count + 2'(push) - 2'(pop);
    end
  end
  assign full = count == 2'd2;
  assign head = count == 2'd0 ? '0 : mem[rd];
endmodule

// File: rtl/rom_frame_reader.sv
// rom_frame_reader: streams one raster frame out of a 1-cycle-latency ROM
module rom_frame_reader
  import rom_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = PIX_DW,
  parameter int IMG_W = DEF_W,
  parameter int IMG_H = DEF_H
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  rom_rd,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [15:0]           pix_x,
  output logic [15:0]           pix_y,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  pix_eof
);
  localparam int LAST = IMG_W * IMG_H - 1;
  rd_state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0] x, y, fl_x, fl_y;
  logic inflight, go, pop, full, last_issue, fl_eol;
  logic [1:0] count;
  pix_beat_t head, beat;
  assign go = start && (state == IDLE || state == DONE);
  assign pop = pix_valid && pix_ready;
  assign rom_rd = state == RUN && (inflight ? count == {1'b0, pop} : (!full || pop));
  assign last_issue = rom_rd && addr == ADDR_WIDTH'(LAST);
  assign fl_eol = fl_x == 16'(IMG_W - 1);
  assign beat = '{data: rom_data, x: fl_x, y: fl_y, sof: fl_x == 16'd0 && fl_y == 16'd0,
                  eol: fl_eol, eof: fl_eol && fl_y == 16'(IMG_H - 1)};
  // frame sequencing: start, last issue, eof handshake, done pulse
  always_comb begin
    state_nx = state;
    if (go) state_nx = RUN;
    else if (state == RUN && last_issue) state_nx = DRAIN;
    else if (state == DRAIN && pop && head.eof) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  // state, issue address/coordinates and the tag of the read in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      x <= '0;
      y <= '0;
      fl_x <= '0;
      fl_y <= '0;
      inflight <= 1'b0;
    end else begin
      state <= state_nx;
      inflight <= rom_rd;
      if (go) begin
        addr <= '0;
        x <= '0;
        y <= '0;
      end else if (rom_rd) begin
        fl_x <= x;
        fl_y <= y;
        addr <= last_issue ? '0 : addr + 1'b1;
        x <= x == 16'(IMG_W - 1) ? '0 : x + 16'd1;
        y <= x == 16'(IMG_W - 1) ? (y == 16'(IMG_H - 1) ? '0 : y + 16'd1) : y;
      end
    end
  end
  rom_skid_buffer u_buf (
    .clk(clk),
    .rst(rst),
    .push(inflight),
    .pop(pop),
    .beat(beat),
    .full(full),
    .count(count),
    .head(head)
  );
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  assign rom_addr = {{(32 - ADDR_WIDTH){1'b0}}, addr};
  assign pix_valid = count != 2'd0;
  assign pix_data = head.data;
  assign pix_x = head.x;
  assign pix_y = head.y;
  assign pix_sof = head.sof;
  assign pix_eol = head.eol;
  assign pix_eof = head.eof;
endmodule
